tl_ul_responder: RTL
====================

TL_UL_RESPONDER -- requirements
Module: tl_ul_responder

Interface
REQ-001 SHALL have parameter BASE, default 30'h0000_1000, meaning the byte base address of the window (aligned to window size).
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of the number of 32-bit words in the window (16 words, 64 bytes).
REQ-003 SHALL have parameter LATENCY, default 2, meaning wait cycles inserted between A acceptance and D valid (0..15).
REQ-004 SHALL have ports: clock  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-006 SHALL have ports: a_valid in 1; a_ready out 1; a_opcode in 3; a_param in 3 (ignored); a_size in 4 (log2 bytes); a_source in 7; a_address in 30; a_mask in 4; a_data in 32 -- TileLink-UL A channel, this block is the manager.
REQ-007 SHALL have ports: d_valid out 1; d_ready in 1; d_opcode out 3; d_param out 2; d_size out 4; d_source out 7; d_denied out 1; d_corrupt out 1; d_data out 32 -- TileLink-UL D channel.

Function
REQ-008 SHALL implement states IDLE, WAIT, RESP; only one transaction outstanding.
REQ-009 SHALL drive a_ready=1 only in IDLE; A fires when a_valid & a_ready.
REQ-010 On A fire SHALL register a_source, a_size, response opcode, denied flag and read data, and go to WAIT if LATENCY>0 else RESP.
REQ-011 WAIT SHALL load a down-counter with LATENCY-1 on entry, decrement each cycle, go to RESP when it reads 0; d_valid rises exactly LATENCY+1 cycles after the A fire edge.
REQ-012 RESP SHALL hold d_valid=1 and all D fields stable until d_ready=1; on d_valid & d_ready go to IDLE (a_ready=1 next cycle; no A/D same-cycle bypass).
REQ-013 Supported opcodes: Get (4) -> AccessAckData (1); PutFullData (0) and PutPartialData (1) -> AccessAck (0); any other opcode -> AccessAck, denied.
REQ-014 Request SHALL be denied if: a_address[29:DEPTH_LOG2+2] != BASE[29:DEPTH_LOG2+2]; a_size > 2; a_address not aligned to 2^a_size; or opcode unsupported.
REQ-015 Word index SHALL be a_address[DEPTH_LOG2+1:2]; non-denied Puts SHALL write byte lanes where a_mask bit=1 at the A fire edge; denied Puts SHALL not write.
REQ-016 Non-denied Get SHALL return the full 32-bit word regardless of a_mask; read captured at fire (after any prior write).
REQ-017 Denied Get SHALL return d_data=0, d_denied=1, d_corrupt=1; denied Put d_denied=1, d_corrupt=0.
REQ-018 d_param SHALL be 0; d_size=a_size and d_source=a_source of the captured request; d_data=0 for AccessAck.
REQ-019 d_valid SHALL not depend combinationally on d_ready; a_ready SHALL not depend combinationally on a_valid.

Reset
REQ-020 While reset=1 at a clock edge: state->IDLE, counter->0, d_valid=0, a_ready=0 during reset and 1 the cycle after release, all D payload outputs 0.
REQ-021 Reset asserted in WAIT or RESP SHALL drop the pending response with no D beat issued; an A fire coincident with reset SHALL be ignored (no write).
REQ-022 Storage contents SHALL not be reset; post-reset reads before any write are unspecified.

Verification
REQ-023 Put 0x11223344 to BASE+0x8, mask 4'hF, size 2, source 5 -> AccessAck, d_source 5, d_denied 0, d_valid at fire+3 cycles (LATENCY=2).
REQ-024 Then PutPartialData 0x0000AA00 mask 4'b0010 at BASE+0x8, then Get size 2 -> AccessAckData d_data 0x1122AA44.
REQ-025 Get at BASE+0x40 (out of window) -> AccessAckData, d_denied 1, d_corrupt 1, d_data 0; Get size 2 at BASE+0x2 -> denied.
REQ-026 Hold d_ready=0 for 10 cycles in RESP -> d_valid and payload stable, a_ready 0 throughout; d_ready=1 -> a_ready 1 next cycle.
REQ-027 Assert reset 1 cycle during WAIT of a Put -> no D beat, d_valid 0, following Get shows write did occur at fire (write precedes reset).
REQ-028 Opcode 2 (ArithmeticData) at BASE -> AccessAck, d_denied 1, memory unchanged; back-to-back A requests accepted one per completed D beat.

Source files
------------

// File: rtl/tl_ul_responder.sv
// rtl/tl_ul_responder.sv - TileLink-UL manager fronting a small word-addressed register window
module tl_ul_responder #(
  parameter logic [29:0] BASE       = 30'h0000_1000,
  parameter int          DEPTH_LOG2 = 4,
  parameter int          LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [3:0]  a_size,
  input  logic [6:0]  a_source,
  input  logic [29:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [3:0]  d_size,
  output logic [6:0]  d_source,
  output logic        d_denied,
  output logic        d_corrupt,
  output logic [31:0] d_data
);

  localparam int         TAG_LSB  = DEPTH_LOG2 + 2;
  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam bit         HAS_WAIT = (LATENCY > 0);
  localparam logic [3:0] LAT_LOAD = HAS_WAIT ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_mem [WORDS];

  logic [2:0]  r_d_opcode;
  logic [3:0]  r_d_size;
  logic [6:0]  r_d_source;
  logic        r_d_denied;
  logic        r_d_corrupt;
  logic [31:0] r_d_data;

  logic                  w_a_fire;
  logic                  w_is_get;
  logic                  w_is_put;
  logic                  w_in_window;
  logic                  w_aligned;
  logic                  w_denied;
  logic                  w_wr_en;
  logic [DEPTH_LOG2-1:0] w_index;
  logic [31:0]           w_rd_word;
  logic                  w_unused_param;

  // a_param carries no meaning for a UL manager
  assign w_unused_param = ^a_param;

  // Request decode: classify opcode and apply window, size and alignment rules
  always_comb begin
    w_is_get    = (a_opcode == 3'd4);
    w_is_put    = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    w_in_window = (a_address[29:TAG_LSB] == BASE[29:TAG_LSB]);
    w_aligned   = (a_size == 4'd0) ||
                  ((a_size == 4'd1) && !a_address[0]) ||
                  ((a_size == 4'd2) && (a_address[1:0] == 2'b00));
    w_denied    = !w_in_window || !w_aligned || !(w_is_get || w_is_put);
    w_index     = a_address[TAG_LSB-1:2];
    w_rd_word   = r_mem[w_index];
    w_a_fire    = a_valid && a_ready;
    w_wr_en     = w_a_fire && w_is_put && !w_denied;
  end

  // Next-state and handshake outputs; a_ready is gated by reset so a
  // request presented during reset is never accepted
  always_comb begin
    w_state_nxt = r_state;
    a_ready     = 1'b0;
    d_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        a_ready = !reset;
        if (a_valid && !reset) begin
          w_state_nxt = HAS_WAIT ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        d_valid = 1'b1;
        if (d_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait counter: loaded when the request is taken, counts down to zero in WAIT
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (w_a_fire) begin
      r_cnt <= LAT_LOAD;
    end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Response capture at A acceptance; the read sees the memory before this
  // request's own write, which is all prior writes since only one is in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      r_d_opcode  <= 3'd0;
      r_d_size    <= 4'd0;
      r_d_source  <= 7'd0;
      r_d_denied  <= 1'b0;
      r_d_corrupt <= 1'b0;
      r_d_data    <= 32'd0;
    end else if (w_a_fire) begin
      r_d_opcode  <= w_is_get ? 3'd1 : 3'd0;
      r_d_size    <= a_size;
      r_d_source  <= a_source;
      r_d_denied  <= w_denied;
      r_d_corrupt <= w_is_get && w_denied;
      r_d_data    <= (w_is_get && !w_denied) ? w_rd_word : 32'd0;
    end
  end

  // Byte-lane writes for accepted Puts; storage is deliberately not reset
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (w_wr_en && a_mask[b]) begin
        r_mem[w_index][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  assign d_opcode  = r_d_opcode;
  assign d_param   = 2'b00;
  assign d_size    = r_d_size;
  assign d_source  = r_d_source;
  assign d_denied  = r_d_denied;
  assign d_corrupt = r_d_corrupt;
  assign d_data    = r_d_data;

endmodule
